// File: rtl/avmm_burst_responder_if.sv
// avmm_burst_responder_if: Avalon-MM burst bus between a DMA-style master and the responder.
// Signals: waitrequest/readdata/readdatavalid driven by the slave;
// address/burstcount/write/writedata/byteenable/read driven by the master.
interface avmm_burst_responder_if #(
    parameter int DATA_WIDTH  = 512,
    parameter int ADDR_WIDTH  = 27,
    parameter int BURST_WIDTH = 7
) ();
    logic                      waitrequest;
    logic [ADDR_WIDTH-1:0]     address;
    logic [BURST_WIDTH-1:0]    burstcount;
    logic                      write;
    logic [DATA_WIDTH-1:0]     writedata;
    logic [DATA_WIDTH/8-1:0]   byteenable;
    logic                      read;
    logic [DATA_WIDTH-1:0]     readdata;
    logic                      readdatavalid;
    modport slave (
        output waitrequest, readdata, readdatavalid,
        input  address, burstcount, write, writedata, byteenable, read
    );
    modport master (
        input  waitrequest, readdata, readdatavalid,
        output address, burstcount, write, writedata, byteenable, read
    );
endinterface

// File: rtl/avmm_burst_responder.sv
// avmm_burst_responder: Avalon-MM burst slave backed by a word-addressed RAM with fixed read latency.
// Ports: clk, reset (async, active-high); avmm (slave modport of the burst bus);
// o_wr_bursts_done / o_rd_bursts_done completed-burst counters; o_proto_err sticky error flag.
module avmm_burst_responder #(
    parameter int DATA_WIDTH   = 512,
    parameter int ADDR_WIDTH   = 27,
    parameter int BURST_WIDTH  = 7,
    parameter int DEPTH_LOG2   = 10,
    parameter int READ_LATENCY = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    avmm_burst_responder_if.slave   avmm,
    output logic [31:0]             o_wr_bursts_done,
    output logic [31:0]             o_rd_bursts_done,
    output logic                    o_proto_err
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int TW    = $clog2(READ_LATENCY + 1);

    typedef enum logic [1:0] {IDLE, WR_BURST, RD_BURST} state_t;

    state_t                  r_state, w_next;
    logic [DATA_WIDTH-1:0]   r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0]   r_addr, w_mem_idx;
    logic [BURST_WIDTH-1:0]  r_bc, r_beat;
    logic [TW-1:0]           r_tick;
    logic                    r_waitreq, r_rdv, r_rd_pend, r_perr;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic [31:0]             r_wr_cnt, r_rd_cnt;
    logic                    w_acc_wr, w_acc_rd, w_bc_zero;
    logic                    w_mem_we, w_wr_done, w_rd_issue, w_rd_last, w_err;
    logic                    w_unused;

    // Only the low DEPTH_LOG2 address bits select a RAM word.
    assign w_unused  = ^avmm.address[ADDR_WIDTH-1:DEPTH_LOG2];
    assign w_acc_wr  = avmm.write && !r_waitreq;
    assign w_acc_rd  = avmm.read && !r_waitreq;
    assign w_bc_zero = avmm.burstcount == '0;

    assign avmm.waitrequest   = r_waitreq;
    assign avmm.readdatavalid = r_rdv;
    assign avmm.readdata      = r_rdata;
    assign o_wr_bursts_done   = r_wr_cnt;
    assign o_rd_bursts_done   = r_rd_cnt;
    assign o_proto_err        = r_perr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_mem_we   = 1'b0;
        w_mem_idx  = r_addr;
        w_wr_done  = 1'b0;
        w_rd_issue = 1'b0;
        w_rd_last  = 1'b0;
        w_err      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_acc_wr) begin
                    // Write wins over a simultaneous read; the read is dropped and flagged.
                    w_err     = w_bc_zero || avmm.read;
                    w_mem_we  = !w_bc_zero;
                    w_mem_idx = avmm.address[DEPTH_LOG2-1:0];
                    w_wr_done = avmm.burstcount == BURST_WIDTH'(1);
                    w_next    = (w_bc_zero || w_wr_done) ? IDLE : WR_BURST;
                end else if (w_acc_rd) begin
                    w_err  = w_bc_zero;
                    w_next = w_bc_zero ? IDLE : RD_BURST;
                end
            end
            WR_BURST: begin
                w_err     = avmm.read;
                w_mem_we  = avmm.write;
                w_wr_done = avmm.write && (r_beat == r_bc - BURST_WIDTH'(1));
                w_next    = w_wr_done ? IDLE : WR_BURST;
            end
            RD_BURST: begin
                // The tick counter saturates at READ_LATENCY-1, so beats then issue back-to-back.
                w_rd_issue = r_tick == TW'(READ_LATENCY - 1);
                w_rd_last  = w_rd_issue && (r_beat == r_bc - BURST_WIDTH'(1));
                w_next     = w_rd_last ? IDLE : RD_BURST;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_mem_we)
            for (int b = 0; b < BE_W; b++)
                if (avmm.byteenable[b]) r_mem[w_mem_idx][b*8 +: 8] <= avmm.writedata[b*8 +: 8];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_waitreq <= 1'b1;
            r_rdv     <= 1'b0;
            r_rdata   <= '0;
            r_rd_pend <= 1'b0;
            r_perr    <= 1'b0;
            r_wr_cnt  <= '0;
            r_rd_cnt  <= '0;
            r_addr    <= '0;
            r_bc      <= '0;
            r_beat    <= '0;
            r_tick    <= '0;
        end else begin
            r_waitreq <= w_next == RD_BURST;
            r_rdv     <= w_rd_issue;
            r_rd_pend <= w_rd_last;
            r_perr    <= r_perr | w_err;
            if (w_rd_issue) r_rdata <= r_mem[r_addr];
            if (w_wr_done) r_wr_cnt <= r_wr_cnt + 32'd1;
            // Read completion is counted one edge after the last beat is presented.
            if (r_rd_pend) r_rd_cnt <= r_rd_cnt + 32'd1;
            if (r_state == IDLE) begin
                // Burst parameters are captured every idle cycle; they matter only once a command is taken.
                r_bc   <= avmm.burstcount;
                r_beat <= BURST_WIDTH'(w_mem_we);
                r_addr <= avmm.address[DEPTH_LOG2-1:0] + DEPTH_LOG2'(w_mem_we);
                r_tick <= '0;
            end else begin
                if (w_mem_we || w_rd_issue) begin
                    r_addr <= r_addr + DEPTH_LOG2'(1);
                    r_beat <= r_beat + BURST_WIDTH'(1);
                end
                if (r_tick != TW'(READ_LATENCY - 1)) r_tick <= r_tick + TW'(1);
            end
        end
    end
endmodule

// File: tb/tb_avmm_burst_responder.sv
// tb_avmm_burst_responder: directed self-checking bench for avmm_burst_responder.
module tb_avmm_burst_responder;
    localparam int DW = 512;
    localparam int AW = 27;
    localparam int BW = 7;
    localparam int L  = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [31:0]   wr_done, rd_done;
    logic          perr;
    int            tests = 0;
    int            fails = 0;
    logic [DW-1:0] exp_q [4];

    avmm_burst_responder_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_WIDTH(BW)) bus ();

    avmm_burst_responder #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_WIDTH(BW), .DEPTH_LOG2(10), .READ_LATENCY(L)
    ) dut (
        .clk(clk),
        .reset(reset),
        .avmm(bus),
        .o_wr_bursts_done(wr_done),
        .o_rd_bursts_done(rd_done),
        .o_proto_err(perr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wbeat(input int a, input int b, input logic [DW-1:0] d, input logic [DW/8-1:0] be);
        chk("wr_waitreq", bus.waitrequest, 0);
        bus.write = 1'b1;
        bus.address = AW'(a);
        bus.burstcount = BW'(b);
        bus.writedata = d;
        bus.byteenable = be;
        tick;
        bus.write = 1'b0;
    endtask

    task automatic rburst(input int a, input int b, input int rd_exp);
        chk("rd_waitreq_pre", bus.waitrequest, 0);
        bus.read = 1'b1;
        bus.address = AW'(a);
        bus.burstcount = BW'(b);
        tick;
        bus.read = 1'b0;
        for (int n = 0; n <= L + b; n++) begin
            chk("rd_waitreq", bus.waitrequest, n < L + b - 1);
            chk("rd_valid", bus.readdatavalid, n >= L && n < L + b);
            if (n >= L && n < L + b) chk("rd_data", bus.readdata, exp_q[n-L]);
            if (n < L + b) tick;
        end
        chk("rd_hold", bus.readdata, exp_q[b-1]);
        chk("rd_count", rd_done, 32'(rd_exp));
    endtask

    initial begin
        bus.write = 1'b0;
        bus.read = 1'b0;
        bus.address = '0;
        bus.burstcount = '0;
        bus.writedata = '0;
        bus.byteenable = '0;
        repeat (2) tick;
        chk("rst_waitreq", bus.waitrequest, 1);
        chk("rst_valid", bus.readdatavalid, 0);
        chk("rst_rdata", bus.readdata, 0);
        chk("rst_wr_cnt", wr_done, 0);
        chk("rst_rd_cnt", rd_done, 0);
        chk("rst_perr", perr, 0);
        reset = 1'b0;
        tick;
        chk("post_rst_waitreq", bus.waitrequest, 0);

        wbeat(5, 1, {64{8'hA5}}, '1);
        chk("t1_wr_cnt", wr_done, 1);
        exp_q[0] = {64{8'hA5}};
        rburst(5, 1, 1);

        wbeat(16, 4, DW'(1), '1);
        wbeat(16, 4, DW'(2), '1);
        tick;
        wbeat(16, 4, DW'(3), '1);
        wbeat(16, 4, DW'(4), '1);
        chk("t2_wr_cnt", wr_done, 2);
        for (int i = 0; i < 4; i++) exp_q[i] = DW'(i + 1);
        rburst(16, 4, 2);

        wbeat(32, 1, {64{8'hFF}}, '1);
        wbeat(32, 1, '0, 64'hF);
        chk("t3_wr_cnt", wr_done, 4);
        exp_q[0] = {{60{8'hFF}}, 32'h0};
        rburst(32, 1, 3);

        for (int i = 0; i < 4; i++) wbeat(1022, 4, DW'(100 + i), '1);
        chk("t4_wr_cnt", wr_done, 5);
        exp_q[0] = DW'(102);
        rburst(0, 1, 4);
        for (int i = 0; i < 4; i++) exp_q[i] = DW'(100 + i);
        rburst(1022, 4, 5);
        chk("t4_perr", perr, 0);

        bus.write = 1'b1;
        bus.read = 1'b1;
        bus.address = AW'(48);
        bus.burstcount = BW'(1);
        bus.writedata = {64{8'h55}};
        bus.byteenable = '1;
        tick;
        bus.write = 1'b0;
        bus.read = 1'b0;
        for (int n = 0; n <= L + 2; n++) begin
            chk("t5_no_valid", bus.readdatavalid, 0);
            tick;
        end
        chk("t5_wr_cnt", wr_done, 6);
        chk("t5_rd_cnt", rd_done, 5);
        chk("t5_perr", perr, 1);
        exp_q[0] = {64{8'h55}};
        rburst(48, 1, 6);

        reset = 1'b1;
        #2;
        chk("rst2_perr", perr, 0);
        chk("rst2_wr_cnt", wr_done, 0);
        chk("rst2_waitreq", bus.waitrequest, 1);
        tick;
        reset = 1'b0;
        tick;

        wbeat(64, 0, '1, '1);
        chk("t6_perr", perr, 1);
        chk("t6_wr_cnt", wr_done, 0);
        chk("t6_waitreq", bus.waitrequest, 0);
        wbeat(64, 1, {64{8'h77}}, '1);
        chk("t6_wr_cnt2", wr_done, 1);

        bus.read = 1'b1;
        bus.address = AW'(16);
        bus.burstcount = BW'(4);
        tick;
        bus.read = 1'b0;
        repeat (L + 1) tick;
        chk("t7_beat1_valid", bus.readdatavalid, 1);
        chk("t7_beat1_data", bus.readdata, DW'(2));
        #2;
        reset = 1'b1;
        #1;
        chk("t7_rst_valid", bus.readdatavalid, 0);
        chk("t7_rst_rdata", bus.readdata, 0);
        chk("t7_rst_wr_cnt", wr_done, 0);
        chk("t7_rst_rd_cnt", rd_done, 0);
        chk("t7_rst_waitreq", bus.waitrequest, 1);
        tick;
        reset = 1'b0;
        tick;
        chk("t7_rel_waitreq", bus.waitrequest, 0);
        exp_q[0] = {64{8'h77}};
        rburst(64, 1, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/avmm_burst_responder.md
# avmm_burst_responder

Avalon-MM burst responder (slave) that terminates a DMA-style burst master such as the streaming DMA's EMIF ports. It stores data in an internal word-addressed RAM and returns read bursts with a fixed, parameterized latency. It is the responding end of the same AVMM burst protocol the DMA drives. It serves as a synthesizable local-memory stand-in and as a protocol checker, with sticky error reporting and completed-burst counters.

## Interface
- DATA_WIDTH, 512, data bus width in bits; a multiple of 8.
- ADDR_WIDTH, 27, word (beat) address width.
- BURST_WIDTH, 7, burstcount width.
- DEPTH_LOG2, 10, log2 of RAM depth in words.
- READ_LATENCY, 4, cycles from read-command acceptance to first readdatavalid; legal range ≥2.
- clk  in  1  single clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high.
- avmm_waitrequest  out  1  backpressure; a transfer is accepted in any cycle where (read|write) && !waitrequest.
- avmm_address  in  ADDR_WIDTH  word address; sampled only on the first beat of a burst.
- avmm_burstcount  in  BURST_WIDTH  beats in the burst; sampled only on the first beat.
- avmm_write  in  1  write beat request.
- avmm_writedata  in  DATA_WIDTH  write data.
- avmm_byteenable  in  DATA_WIDTH/8  per-byte write mask; applied on every write beat.
- avmm_read  in  1  read command request.
- avmm_readdata  out  DATA_WIDTH  read data.
- avmm_readdatavalid  out  1  qualifies readdata, one beat per cycle.
- wr_bursts_done  out  32  count of completed write bursts; wraps modulo 2^32.
- rd_bursts_done  out  32  count of completed read bursts; wraps modulo 2^32.
- proto_err  out  1  sticky protocol-error flag; cleared only by reset.

## Operation
- RAM index = (burst base address + beat index) mod 2^DEPTH_LOG2. Upper address bits are ignored, so wrap-around within a burst is silent.
- RAM contents are not reset. A read of a never-written word returns unspecified data.
- FSM states:
  - IDLE → WR_BURST: write accepted with burstcount > 1. Beat 0 is written immediately.
  - IDLE stays IDLE: write accepted with burstcount == 1. The single beat is written and wr_bursts_done increments.
  - IDLE → RD_BURST: read accepted with burstcount ≥ 1.
  - WR_BURST: waitrequest is low. Each accepted write beat stores data to base+i under byteenable. Gaps with write low are allowed. The final beat (i == burstcount-1) increments wr_bursts_done and returns the FSM to IDLE.
  - RD_BURST: waitrequest is high. B beats are issued from base+0 … base+B-1. After the last readdatavalid beat, rd_bursts_done increments and the FSM returns to IDLE.
- Only one burst is outstanding at a time; no read pipelining across commands.
- Byte lanes with byteenable=0 keep their old RAM content. Bytes with byteenable=1 are replaced.
- proto_err sets in these cases:
  - burstcount == 0 on a command. The command is consumed with no RAM access and no counter change.
  - read and write both high in IDLE. Write wins; the read is dropped.
  - read high during WR_BURST. It is ignored.

## Timing
- Reset values: avmm_waitrequest=1, avmm_readdatavalid=0, avmm_readdata=0, wr_bursts_done=0, rd_bursts_done=0, proto_err=0, state=IDLE.
- waitrequest goes low on the first rising edge after reset deasserts and stays low in IDLE and WR_BURST.
- Read command accepted at edge c:
  - beat k (0 ≤ k < B) has readdatavalid=1 in the cycle following edge c+READ_LATENCY+k; beats are strictly back-to-back.
  - waitrequest is high from edge c until the edge that presents the last beat.
  - waitrequest is low, accepting a new command, in the cycle following edge c+READ_LATENCY+B-1.
- readdata holds its last value when readdatavalid=0.
- Write-after-write to the same word in consecutive cycles: the last write wins.
- Write followed immediately by a read of the same word returns the new data; no stale read is permitted.
- Counters update on the same edge as the completing beat (write) or one edge after the last readdatavalid beat is presented (read). Either way the update is visible the next cycle.
- Reset asserted mid-burst: all outputs take their reset values immediately and asynchronously. In-flight read beats are discarded. Write beats already accepted remain in RAM.
- Maximum burst is 2^BURST_WIDTH-1 beats. No internal limit applies other than address wrap.

## Test plan
- Reset, then a single write to address 5 with data 0xA5 replicated and byteenable all-ones. A 1-beat read of address 5 then returns 0xA5… in the cycle following edge c+4. wr_bursts_done=1, rd_bursts_done=1.
- 4-beat write to base 0x10 with data i+1, inserting one idle gap after beat 1. A 4-beat read of 0x10 returns 1,2,3,4 on consecutive cycles. waitrequest is high for exactly READ_LATENCY+3 cycles after acceptance.
- Byteenable test: write all-0xFF, then write all-0x00 with byteenable=0x…0F. A read returns 0xFF everywhere except bytes 0–3, which read 0x00.
- Wrap-around with DEPTH_LOG2=10: a 4-beat write at word 1022 lands at words 1022, 1023, 0, 1. A read of address 0 returns beat 2. proto_err stays 0.
- Protocol errors:
  - burstcount=0 write: proto_err=1, wr_bursts_done unchanged.
  - simultaneous read+write in IDLE: the write is performed and the read gets no readdatavalid.
- Reset asserted during read beat 1 of 4: readdatavalid drops immediately and all counters read 0. Afterwards, waitrequest is low one edge after reset release and a fresh read succeeds.
